// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - mode constants and width helpers for the KNN sorted neighbour list
package knn_pkg;

  localparam int MODE_MIN = 0;
  localparam int MODE_MAX = 1;

  function automatic int knn_idx_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic int knn_cnt_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_list_cell.sv
// rtl/knn_list_cell.sv - one entry of the sorted list: holds vld/dist/label, flags when the candidate beats it
module knn_list_cell
  import knn_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int MODE    = MODE_MIN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_accept,
  input  logic [DATA_W-1:0]  i_cand_dist,
  input  logic [LABEL_W-1:0] i_cand_label,
  input  logic               i_prev_vld,
  input  logic               i_prev_better,
  input  logic [DATA_W-1:0]  i_prev_dist,
  input  logic [LABEL_W-1:0] i_prev_label,
  output logic               o_vld,
  output logic               o_better,
  output logic [DATA_W-1:0]  o_dist,
  output logic [LABEL_W-1:0] o_label
);

  logic               r_vld;
  logic [DATA_W-1:0]  r_dist;
  logic [LABEL_W-1:0] r_label;
  logic               w_cmp;

  // Strict compare: an equal distance never displaces, so first-seen wins on ties.
  assign w_cmp    = (MODE == MODE_MIN) ? (i_cand_dist < r_dist) : (i_cand_dist > r_dist);
  assign o_better = ~r_vld | w_cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_dist  <= '0;
      r_label <= '0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (i_accept && o_better) begin
      // Previous cell also beaten: the insertion point is above, so shift its entry down.
      if (i_prev_better) begin
        r_vld   <= i_prev_vld;
        r_dist  <= i_prev_dist;
        r_label <= i_prev_label;
      end else begin
        r_vld   <= 1'b1;
        r_dist  <= i_cand_dist;
        r_label <= i_cand_label;
      end
    end
  end

  assign o_vld   = r_vld;
  assign o_dist  = r_dist;
  assign o_label = r_label;

endmodule

// File: rtl/knn_sorted_list.sv
// rtl/knn_sorted_list.sv - K-deep best-first neighbour list with occupancy, worst distance and read port
module knn_sorted_list
  import knn_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int K       = 10,
  parameter int MODE    = MODE_MIN,
  parameter int IDX_W   = knn_idx_w(K),
  parameter int CNT_W   = knn_cnt_w(K)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cand_valid,
  output logic               cand_ready,
  input  logic [DATA_W-1:0]  cand_dist,
  input  logic [LABEL_W-1:0] cand_label,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_vld,
  output logic [DATA_W-1:0]  rd_dist,
  output logic [LABEL_W-1:0] rd_label,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic [DATA_W-1:0]  worst_dist,
  output logic               ins_hit
);

  localparam logic [DATA_W-1:0] EMPTY_WORST = (MODE == MODE_MIN) ? '1 : '0;

  logic               w_accept;
  logic [K-1:0]       w_vld;
  logic [K-1:0]       w_better;
  logic [DATA_W-1:0]  w_dist  [K];
  logic [LABEL_W-1:0] w_label [K];
  logic [CNT_W-1:0]   r_count;
  logic               r_ins_hit;

  assign cand_ready = ~clr;
  assign w_accept   = cand_valid & cand_ready;

  for (genvar gi = 0; gi < K; gi++) begin : g_cell
    logic               w_prev_vld;
    logic               w_prev_better;
    logic [DATA_W-1:0]  w_prev_dist;
    logic [LABEL_W-1:0] w_prev_label;

    if (gi == 0) begin : g_head
      assign w_prev_vld    = 1'b0;
      assign w_prev_better = 1'b0;
      assign w_prev_dist   = '0;
      assign w_prev_label  = '0;
    end else begin : g_link
      assign w_prev_vld    = w_vld[gi-1];
      assign w_prev_better = w_better[gi-1];
      assign w_prev_dist   = w_dist[gi-1];
      assign w_prev_label  = w_label[gi-1];
    end

    knn_list_cell #(
      .DATA_W  (DATA_W),
      .LABEL_W (LABEL_W),
      .MODE    (MODE)
    ) u_cell (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clr         (clr),
      .i_accept      (w_accept),
      .i_cand_dist   (cand_dist),
      .i_cand_label  (cand_label),
      .i_prev_vld    (w_prev_vld),
      .i_prev_better (w_prev_better),
      .i_prev_dist   (w_prev_dist),
      .i_prev_label  (w_prev_label),
      .o_vld         (w_vld[gi]),
      .o_better      (w_better[gi]),
      .o_dist        (w_dist[gi]),
      .o_label       (w_label[gi])
    );
  end

  // The last cell is beaten whenever the candidate lands anywhere in the list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_ins_hit <= 1'b0;
    end else if (clr) begin
      r_count   <= '0;
      r_ins_hit <= 1'b0;
    end else begin
      r_ins_hit <= w_accept & w_better[K-1];
      if (w_accept && w_better[K-1] && (r_count != CNT_W'(K)))
        r_count <= r_count + 1'b1;
    end
  end

  assign count      = r_count;
  assign full       = (r_count == CNT_W'(K));
  assign worst_dist = full ? w_dist[K-1] : EMPTY_WORST;
  assign ins_hit    = r_ins_hit;

  always_comb begin
    rd_vld   = 1'b0;
    rd_dist  = '0;
    rd_label = '0;
    for (int i = 0; i < K; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_vld   = w_vld[i];
        rd_dist  = w_dist[i];
        rd_label = w_label[i];
      end
    end
  end

endmodule

// File: tb/tb_knn_sorted_list.sv
// tb/tb_knn_sorted_list.sv - scoreboard bench for knn_sorted_list (K=4, 8-bit distance, 4-bit label)
module tb_knn_sorted_list;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       cand_valid = 1'b0;
  logic [7:0] cand_dist = '0;
  logic [3:0] cand_label = '0;
  logic [1:0] rd_idx0 = '0;
  logic [1:0] rd_idx1 = '0;

  logic       ready0, vld0, full0, hit0;
  logic [7:0] dist0, worst0;
  logic [3:0] label0;
  logic [2:0] count0;
  logic       ready1, vld1, full1, hit1;
  logic [7:0] dist1, worst1;
  logic [3:0] label1;
  logic [2:0] count1;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  knn_sorted_list #(.DATA_W(8), .LABEL_W(4), .K(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cand_valid(cand_valid), .cand_ready(ready0),
    .cand_dist(cand_dist), .cand_label(cand_label), .rd_idx(rd_idx0), .rd_vld(vld0),
    .rd_dist(dist0), .rd_label(label0), .count(count0), .full(full0),
    .worst_dist(worst0), .ins_hit(hit0)
  );

  knn_sorted_list #(.DATA_W(8), .LABEL_W(4), .K(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cand_valid(cand_valid), .cand_ready(ready1),
    .cand_dist(cand_dist), .cand_label(cand_label), .rd_idx(rd_idx1), .rd_vld(vld1),
    .rd_dist(dist1), .rd_label(label1), .count(count1), .full(full1),
    .worst_dist(worst1), .ins_hit(hit1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model of the MODE 0 instance: plain array insertion, ties go after equals.
  logic       m_vld [4];
  logic [7:0] m_d   [4];
  logic [3:0] m_l   [4];
  int         m_cnt;
  logic       m_hit;

  typedef struct packed {
    logic [2:0]  cnt;
    logic        full;
    logic [7:0]  worst;
    logic        hit;
    logic [3:0]  vld;
    logic [31:0] d;
    logic [15:0] l;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_vld[i] = 1'b0; m_d[i] = '0; m_l[i] = '0;
    end
    m_cnt = 0;
    m_hit = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
    m_cnt = 0;
    m_hit = 1'b0;
  endtask

  task automatic model_insert(input logic [7:0] d, input logic [3:0] l);
    int pos = 4;
    for (int i = 0; i < 4; i++)
      if (pos == 4 && (!m_vld[i] || d < m_d[i])) pos = i;
    m_hit = (pos < 4);
    if (m_hit) begin
      for (int i = 3; i > pos; i--) begin
        m_vld[i] = m_vld[i-1]; m_d[i] = m_d[i-1]; m_l[i] = m_l[i-1];
      end
      m_vld[pos] = 1'b1; m_d[pos] = d; m_l[pos] = l;
      if (m_cnt < 4) m_cnt++;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.cnt   = 3'(m_cnt);
    e.full  = (m_cnt == 4);
    e.worst = (m_cnt == 4) ? m_d[3] : 8'hFF;
    e.hit   = m_hit;
    for (int i = 0; i < 4; i++) begin
      e.vld[i]       = m_vld[i];
      e.d[i*8 +: 8]  = m_d[i];
      e.l[i*4 +: 4]  = m_l[i];
    end
    sb_q.push_back(e);
  endtask

  // Called on a falling edge; drives one cycle of stimulus and returns on the next falling edge.
  task automatic drive(input logic v, input logic c, input logic [7:0] d, input logic [3:0] l);
    cand_valid = v; clr = c; cand_dist = d; cand_label = l;
    #1;
    check("cand_ready0", 32'(ready0), 32'(!c));
    check("cand_ready1", 32'(ready1), 32'(!c));
    @(posedge clk);
    if (c) model_clear();
    else if (v) model_insert(d, l);
    else m_hit = 1'b0;
    push_expect();
    @(negedge clk);
    cand_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic exp_entry0(input int i, input logic [7:0] d, input logic [3:0] l);
    rd_idx0 = 2'(i); #1;
    check($sformatf("dut0_vld%0d", i), 32'(vld0), 32'd1);
    check($sformatf("dut0_dist%0d", i), 32'(dist0), 32'(d));
    check($sformatf("dut0_label%0d", i), 32'(label0), 32'(l));
  endtask

  task automatic exp_entry1(input int i, input logic [7:0] d, input logic [3:0] l);
    rd_idx1 = 2'(i); #1;
    check($sformatf("dut1_vld%0d", i), 32'(vld1), 32'd1);
    check($sformatf("dut1_dist%0d", i), 32'(dist1), 32'(d));
    check($sformatf("dut1_label%0d", i), 32'(label1), 32'(l));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_count", 32'(count0), 32'(e.cnt));
        check("sb_full", 32'(full0), 32'(e.full));
        check("sb_worst", 32'(worst0), 32'(e.worst));
        check("sb_ins_hit", 32'(hit0), 32'(e.hit));
        for (int i = 0; i < 4; i++) begin
          rd_idx0 = 2'(i); #1;
          check($sformatf("sb_vld%0d", i), 32'(vld0), 32'(e.vld[i]));
          if (e.vld[i]) begin
            check($sformatf("sb_dist%0d", i), 32'(dist0), 32'(e.d[i*8 +: 8]));
            check($sformatf("sb_label%0d", i), 32'(label0), 32'(e.l[i*4 +: 4]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] d5 [5];
    logic [3:0] l5 [5];
    model_reset();

    @(negedge clk);
    check("rst_count", 32'(count0), 32'd0);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_hit", 32'(hit0), 32'd0);
    check("rst_worst0", 32'(worst0), 32'hFF);
    check("rst_worst1", 32'(worst1), 32'h00);
    check("rst_ready", 32'(ready0), 32'd1);
    rd_idx0 = 2'd0; #1;
    check("rst_vld0", 32'(vld0), 32'd0);
    check("rst_dist0", 32'(dist0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 0, 8'd50, 4'd1);
    drive(1, 0, 8'd20, 4'd2);
    drive(1, 0, 8'd80, 4'd3);
    drive(1, 0, 8'd10, 4'd4);
    @(posedge clk); #1;
    exp_entry0(0, 8'd10, 4'd4);
    exp_entry0(1, 8'd20, 4'd2);
    exp_entry0(2, 8'd50, 4'd1);
    exp_entry0(3, 8'd80, 4'd3);
    check("t1_count", 32'(count0), 32'd4);
    check("t1_full", 32'(full0), 32'd1);
    check("t1_worst", 32'(worst0), 32'd80);
    @(negedge clk);

    drive(1, 0, 8'd90, 4'd9);
    check("t2_hit90", 32'(hit0), 32'd0);
    drive(1, 0, 8'd30, 4'd5);
    check("t2_hit30", 32'(hit0), 32'd1);
    @(posedge clk); #1;
    exp_entry0(0, 8'd10, 4'd4);
    exp_entry0(1, 8'd20, 4'd2);
    exp_entry0(2, 8'd30, 4'd5);
    exp_entry0(3, 8'd50, 4'd1);
    check("t2_worst", 32'(worst0), 32'd50);
    @(negedge clk);

    drive(1, 0, 8'd20, 4'd6);
    check("t3_hit20", 32'(hit0), 32'd1);
    drive(1, 0, 8'd30, 4'd8);
    check("t3_hit30", 32'(hit0), 32'd0);
    @(posedge clk); #1;
    exp_entry0(0, 8'd10, 4'd4);
    exp_entry0(1, 8'd20, 4'd2);
    exp_entry0(2, 8'd20, 4'd6);
    exp_entry0(3, 8'd30, 4'd5);
    @(negedge clk);

    drive(1, 1, 8'd5, 4'd7);
    @(posedge clk); #1;
    check("t4_count", 32'(count0), 32'd0);
    check("t4_full", 32'(full0), 32'd0);
    check("t4_worst", 32'(worst0), 32'hFF);
    for (int i = 0; i < 4; i++) begin
      rd_idx0 = 2'(i); #1;
      check($sformatf("t4_vld%0d", i), 32'(vld0), 32'd0);
    end
    @(negedge clk);
    drive(1, 0, 8'd5, 4'd7);
    @(posedge clk); #1;
    exp_entry0(0, 8'd5, 4'd7);
    check("t4_count1", 32'(count0), 32'd1);
    @(negedge clk);

    drive(0, 1, 8'd0, 4'd0);
    d5 = '{8'd50, 8'd20, 8'd80, 8'd10, 8'd60};
    l5 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    for (int i = 0; i < 5; i++) drive(1, 0, d5[i], l5[i]);
    @(posedge clk); #1;
    exp_entry1(0, 8'd80, 4'd3);
    exp_entry1(1, 8'd60, 4'd5);
    exp_entry1(2, 8'd50, 4'd1);
    exp_entry1(3, 8'd20, 4'd2);
    check("t5_worst", 32'(worst1), 32'd20);
    check("t5_count", 32'(count1), 32'd4);
    @(negedge clk);

    cand_valid = 1'b1; cand_dist = 8'd40; cand_label = 4'd1;
    @(posedge clk); #1;
    check("t6_pre_hit", 32'(hit0), 32'd1);
    #1;
    rst_n = 1'b0; cand_valid = 1'b0;
    #1;
    check("t6_count", 32'(count0), 32'd0);
    check("t6_full", 32'(full0), 32'd0);
    check("t6_hit", 32'(hit0), 32'd0);
    check("t6_worst0", 32'(worst0), 32'hFF);
    check("t6_worst1", 32'(worst1), 32'h00);
    check("t6_ready", 32'(ready0), 32'd1);
    rd_idx0 = 2'd0; #1;
    check("t6_vld0", 32'(vld0), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 8'd70, 4'd2);
    @(posedge clk); #1;
    exp_entry0(0, 8'd70, 4'd2);
    check("t6_count1", 32'(count0), 32'd1);
    @(negedge clk);

    drive(0, 1, 8'd0, 4'd0);
    for (int n = 0; n < 30; n++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            8'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    @(negedge clk); #6;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
